// File: rtl/player_sprite_ctrl.sv
// Player sprite controller: button auto-repeat, clamped movement with per-direction
// permits, lives / invulnerability / death handling, and renderer-facing buses.
module player_sprite_ctrl #(
    parameter int unsigned OBJ_W         = 32'd12,
    parameter int unsigned OBJ_H         = 32'd12,
    parameter int unsigned H_START       = 32'd308,
    parameter int unsigned V_START       = 32'd372,
    parameter int unsigned H_MIN         = 32'd0,
    parameter int unsigned H_MAX         = 32'd628,
    parameter int unsigned V_MIN         = 32'd0,
    parameter int unsigned V_MAX         = 32'd468,
    parameter int unsigned STEP          = 32'd4,
    parameter int unsigned REPEAT_DELAY  = 32'd16,
    parameter int unsigned REPEAT_PERIOD = 32'd4,
    parameter int unsigned LIVES         = 32'd3,
    parameter int unsigned INVULN_CYCLES = 32'd64,
    parameter int unsigned BLINK         = 32'd8
) (
    input  logic        btnClk,
    input  logic        rst,
    input  logic [3:0]  btns,
    input  logic        upEnable,
    input  logic        downEnable,
    input  logic        leftEnable,
    input  logic        rightEnable,
    input  logic        hit,
    input  logic        respawn,
    input  logic [2:0]  color,
    output logic [31:0] hPos,
    output logic [31:0] vPos,
    output logic [31:0] hOffset,
    output logic [31:0] vOffset,
    output logic [31:0] hStartPos_o,
    output logic [31:0] vStartPos_o,
    output logic [31:0] objWidth,
    output logic [31:0] objHeight,
    output logic [3:0]  color_o,
    output logic [2:0]  status,
    output logic [3:0]  lives
);

    typedef enum logic [2:0] {
        ST_ALIVE   = 3'd0,
        ST_MOVING  = 3'd1,
        ST_BLOCKED = 3'd2,
        ST_HIT     = 3'd3,
        ST_DEAD    = 3'd4
    } state_t;

    localparam logic [31:0] H_START_C = 32'(H_START);
    localparam logic [31:0] V_START_C = 32'(V_START);
    localparam logic [31:0] H_MIN_C   = 32'(H_MIN);
    localparam logic [31:0] H_MAX_C   = 32'(H_MAX);
    localparam logic [31:0] V_MIN_C   = 32'(V_MIN);
    localparam logic [31:0] V_MAX_C   = 32'(V_MAX);
    localparam logic [31:0] STEP_C    = 32'(STEP);
    localparam logic [15:0] DELAY_C   = 16'(REPEAT_DELAY);
    // After the first repeat the counter is rewound so it hits DELAY_C again one period later.
    localparam logic [15:0] RELOAD_C  = 16'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [15:0] INVULN_C  = 16'(INVULN_CYCLES - 32'd1);
    localparam logic [15:0] BLINK_C   = 16'(BLINK);
    localparam logic [3:0]  LIVES_C   = 4'(LIVES);
    localparam logic [3:0]  GREY_C    = 4'b1000;

    state_t            state_r;
    state_t            move_status_s;
    logic [3:0]        btn_prev_r;
    logic [3:0][15:0]  hold_cnt_r;
    logic [3:0][15:0]  hold_nxt_s;
    logic [3:0]        req_s;
    logic              up_s, down_s, left_s, right_s;
    logic [31:0]       h_pos_r, v_pos_r, h_nxt_s, v_nxt_s;
    logic              h_moved_s, v_moved_s, h_denied_s, v_denied_s;
    logic [3:0]        lives_r;
    logic [3:0]        color_r;
    logic [3:0]        base_color_s;
    logic [15:0]       hit_timer_r;
    logic [15:0]       blink_cnt_r;
    logic              blink_on_r;

    assign base_color_s = {1'b0, color};

    // Per-direction press detection and auto-repeat request generation.
    always_comb begin
        req_s      = 4'b0000;
        hold_nxt_s = '0;
        for (int d = 0; d < 4; d++) begin
            if (btns[d] && !btn_prev_r[d]) begin
                req_s[d]      = 1'b1;
                hold_nxt_s[d] = 16'd0;
            end else if (btns[d]) begin
                if (hold_cnt_r[d] + 16'd1 == DELAY_C) begin
                    req_s[d]      = 1'b1;
                    hold_nxt_s[d] = RELOAD_C;
                end else begin
                    hold_nxt_s[d] = hold_cnt_r[d] + 16'd1;
                end
            end else begin
                hold_nxt_s[d] = 16'd0;
            end
        end
    end

    assign up_s    = req_s[0] & ~req_s[1];
    assign down_s  = req_s[1] & ~req_s[0];
    assign left_s  = req_s[2] & ~req_s[3];
    assign right_s = req_s[3] & ~req_s[2];

    // Horizontal move: grant, clamp, or report denial.
    always_comb begin
        h_nxt_s    = h_pos_r;
        h_moved_s  = 1'b0;
        h_denied_s = 1'b0;
        if (right_s) begin
            if (rightEnable && (h_pos_r < H_MAX_C)) begin
                h_moved_s = 1'b1;
                h_nxt_s   = (h_pos_r > H_MAX_C - STEP_C) ? H_MAX_C : h_pos_r + STEP_C;
            end else begin
                h_denied_s = 1'b1;
            end
        end else if (left_s) begin
            if (leftEnable && (h_pos_r > H_MIN_C)) begin
                h_moved_s = 1'b1;
                h_nxt_s   = (h_pos_r < H_MIN_C + STEP_C) ? H_MIN_C : h_pos_r - STEP_C;
            end else begin
                h_denied_s = 1'b1;
            end
        end else begin
            h_nxt_s = h_pos_r;
        end
    end

    // Vertical move: grant, clamp, or report denial.
    always_comb begin
        v_nxt_s    = v_pos_r;
        v_moved_s  = 1'b0;
        v_denied_s = 1'b0;
        if (down_s) begin
            if (downEnable && (v_pos_r < V_MAX_C)) begin
                v_moved_s = 1'b1;
                v_nxt_s   = (v_pos_r > V_MAX_C - STEP_C) ? V_MAX_C : v_pos_r + STEP_C;
            end else begin
                v_denied_s = 1'b1;
            end
        end else if (up_s) begin
            if (upEnable && (v_pos_r > V_MIN_C)) begin
                v_moved_s = 1'b1;
                v_nxt_s   = (v_pos_r < V_MIN_C + STEP_C) ? V_MIN_C : v_pos_r - STEP_C;
            end else begin
                v_denied_s = 1'b1;
            end
        end else begin
            v_nxt_s = v_pos_r;
        end
    end

    // Status a normal-state cycle would report.
    always_comb begin
        if (h_moved_s || v_moved_s) begin
            move_status_s = ST_MOVING;
        end else if (h_denied_s || v_denied_s) begin
            move_status_s = ST_BLOCKED;
        end else begin
            move_status_s = ST_ALIVE;
        end
    end

    // Player state machine with registered position, lives and colour.
    always_ff @(posedge btnClk) begin
        if (!rst) begin
            state_r     <= ST_ALIVE;
            h_pos_r     <= H_START_C;
            v_pos_r     <= V_START_C;
            lives_r     <= LIVES_C;
            color_r     <= base_color_s;
            btn_prev_r  <= 4'b0000;
            hold_cnt_r  <= '0;
            hit_timer_r <= 16'd0;
            blink_cnt_r <= 16'd0;
            blink_on_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_DEAD: begin
                    if (respawn) begin
                        state_r    <= ST_ALIVE;
                        h_pos_r    <= H_START_C;
                        v_pos_r    <= V_START_C;
                        lives_r    <= LIVES_C;
                        btn_prev_r <= 4'b0000;
                        hold_cnt_r <= '0;
                        color_r    <= base_color_s;
                    end else begin
                        btn_prev_r <= btns;
                        hold_cnt_r <= hold_nxt_s;
                        color_r    <= GREY_C;
                    end
                end
                ST_HIT: begin
                    btn_prev_r <= btns;
                    hold_cnt_r <= hold_nxt_s;
                    h_pos_r    <= h_nxt_s;
                    v_pos_r    <= v_nxt_s;
                    if (hit_timer_r == 16'd0) begin
                        state_r <= move_status_s;
                        color_r <= base_color_s;
                    end else begin
                        hit_timer_r <= hit_timer_r - 16'd1;
                        if (blink_cnt_r + 16'd1 == BLINK_C) begin
                            blink_cnt_r <= 16'd0;
                            blink_on_r  <= ~blink_on_r;
                            color_r     <= blink_on_r ? 4'b0000 : base_color_s;
                        end else begin
                            blink_cnt_r <= blink_cnt_r + 16'd1;
                            color_r     <= blink_on_r ? base_color_s : 4'b0000;
                        end
                    end
                end
                default: begin
                    btn_prev_r <= btns;
                    hold_cnt_r <= hold_nxt_s;
                    h_pos_r    <= h_nxt_s;
                    v_pos_r    <= v_nxt_s;
                    if (hit) begin
                        lives_r <= lives_r - 4'd1;
                        if (lives_r == 4'd1) begin
                            state_r <= ST_DEAD;
                            color_r <= GREY_C;
                        end else begin
                            state_r     <= ST_HIT;
                            hit_timer_r <= INVULN_C;
                            blink_cnt_r <= 16'd0;
                            blink_on_r  <= 1'b1;
                            color_r     <= base_color_s;
                        end
                    end else begin
                        state_r <= move_status_s;
                        color_r <= base_color_s;
                    end
                end
            endcase
        end
    end

    assign hPos        = h_pos_r;
    assign vPos        = v_pos_r;
    assign hOffset     = h_pos_r - H_START_C;
    assign vOffset     = v_pos_r - V_START_C;
    assign hStartPos_o = H_START_C;
    assign vStartPos_o = V_START_C;
    assign objWidth    = 32'(OBJ_W);
    assign objHeight   = 32'(OBJ_H);
    assign color_o     = color_r;
    assign status      = state_r;
    assign lives       = lives_r;

endmodule

// File: tb/tb_player_sprite_ctrl.sv
// Bench for player_sprite_ctrl: directed scenarios plus random stimulus, every
// cycle compared against a rule-level model of the sprite behaviour.
module tb_player_sprite_ctrl;

    localparam int H_ST = 308, V_ST = 372, H_MX = 628, V_MX = 468, STP = 4;
    localparam int DLY = 16, PER = 4, NLIVES = 3, INV = 64, BLK = 8;

    logic        btnClk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  btns = 4'b0000;
    logic [3:0]  en = 4'b1111;
    logic        hit = 1'b0, respawn = 1'b0;
    logic [2:0]  color = 3'd5;
    logic [31:0] hPos, vPos, hOffset, vOffset, hStartPos_o, vStartPos_o, objWidth, objHeight;
    logic [3:0]  color_o, lives;
    logic [2:0]  status;

    int n_checks = 0;
    int n_fail = 0;

    // model state: positions, lives, status code, edges spent in HIT, press ages
    int m_h, m_v, m_lives, m_st, m_hit_age;
    int m_age[4];
    bit m_prev[4];
    int m_col;

    player_sprite_ctrl dut (
        .btnClk(btnClk), .rst(rst), .btns(btns),
        .upEnable(en[0]), .downEnable(en[1]), .leftEnable(en[2]), .rightEnable(en[3]),
        .hit(hit), .respawn(respawn), .color(color),
        .hPos(hPos), .vPos(vPos), .hOffset(hOffset), .vOffset(vOffset),
        .hStartPos_o(hStartPos_o), .vStartPos_o(vStartPos_o),
        .objWidth(objWidth), .objHeight(objHeight),
        .color_o(color_o), .status(status), .lives(lives)
    );

    always #5 btnClk = ~btnClk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    task automatic model_reset();
        m_h = H_ST; m_v = V_ST; m_lives = NLIVES; m_st = 0; m_hit_age = 0;
        for (int d = 0; d < 4; d++) begin
            m_age[d] = -1; m_prev[d] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit rq[4];
        int dh, dv, norm;
        bit moved, denied;
        int base;
        base = int'(color);
        if (!rst) begin
            model_reset();
            m_col = base;
            return;
        end
        for (int d = 0; d < 4; d++) begin
            if (btns[d]) begin
                m_age[d] = m_prev[d] ? m_age[d] + 1 : 0;
                rq[d] = (m_age[d] == 0) || (m_age[d] >= DLY && (m_age[d] - DLY) % PER == 0);
            end else begin
                m_age[d] = -1;
                rq[d] = 1'b0;
            end
            m_prev[d] = btns[d];
        end
        if (m_st == 4) begin
            if (respawn) begin
                model_reset();
                m_col = base;
            end else begin
                m_col = 8;
            end
            return;
        end
        dh = int'(rq[3]) - int'(rq[2]);
        dv = int'(rq[1]) - int'(rq[0]);
        moved = 1'b0; denied = 1'b0;
        if (dh != 0) begin
            if ((dh > 0 && en[3] && m_h < H_MX) || (dh < 0 && en[2] && m_h > 0)) begin
                m_h = clamp(m_h + dh * STP, 0, H_MX); moved = 1'b1;
            end else denied = 1'b1;
        end
        if (dv != 0) begin
            if ((dv > 0 && en[1] && m_v < V_MX) || (dv < 0 && en[0] && m_v > 0)) begin
                m_v = clamp(m_v + dv * STP, 0, V_MX); moved = 1'b1;
            end else denied = 1'b1;
        end
        norm = moved ? 1 : (denied ? 2 : 0);
        if (m_st == 3) begin
            m_hit_age++;
            if (m_hit_age == INV) begin
                m_st = norm; m_col = base;
            end else begin
                m_col = ((m_hit_age / BLK) % 2 == 0) ? base : 0;
            end
        end else if (hit) begin
            m_lives--;
            m_st = (m_lives == 0) ? 4 : 3;
            m_hit_age = 0;
            m_col = (m_lives == 0) ? 8 : base;
        end else begin
            m_st = norm; m_col = base;
        end
    endtask

    task automatic step();
        @(posedge btnClk);
        model_step();
        #1;
        check_val("hPos", hPos, 32'(m_h));
        check_val("vPos", vPos, 32'(m_v));
        check_val("hOffset", hOffset, 32'(m_h - H_ST));
        check_val("vOffset", vOffset, 32'(m_v - V_ST));
        check_val("color_o", 32'(color_o), 32'(m_col));
        check_val("status", 32'(status), 32'(m_st));
        check_val("lives", 32'(lives), 32'(m_lives));
    endtask

    task automatic do_reset();
        rst = 1'b0; step(); rst = 1'b1;
    endtask

    initial begin
        model_reset();
        m_col = 0;
        rst = 1'b0; step(); step(); rst = 1'b1;
        check_val("hStart", hStartPos_o, 32'd308);
        check_val("vStart", vStartPos_o, 32'd372);
        check_val("objW", objWidth, 32'd12);
        check_val("objH", objHeight, 32'd12);

        // single right press
        btns = 4'b1000; step();
        check_val("right_pos", hPos, 32'd312);
        check_val("right_moving", 32'(status), 32'd1);
        btns = 4'b0000; step();
        check_val("right_alive", 32'(status), 32'd0);
        check_val("right_off", hOffset, 32'd4);

        // hold left 30 cycles from start
        do_reset();
        btns = 4'b0100;
        repeat (30) step();
        check_val("hold_left", hPos, 32'd288);
        btns = 4'b0000; step();

        // right not permitted
        en = 4'b0111; btns = 4'b1000; step();
        check_val("blocked_pos", hPos, 32'd288);
        check_val("blocked_st", 32'(status), 32'd2);
        btns = 4'b0000; en = 4'b1111; step();

        // up to the top bound, then a denied press
        btns = 4'b0001;
        repeat (420) step();
        check_val("top_bound", vPos, 32'd0);
        btns = 4'b0000; step();
        btns = 4'b0001; step();
        check_val("top_blocked", 32'(status), 32'd2);
        btns = 4'b0000; step();

        // up+down cancel while left moves
        do_reset();
        btns = 4'b0111;
        repeat (20) step();
        check_val("cancel_v", vPos, 32'd372);
        check_val("cancel_h", hPos, 32'd300);
        check_val("cancel_off", hOffset, 32'hFFFF_FFF8);
        btns = 4'b0000; step();

        // three hits to death
        for (int k = 0; k < 3; k++) begin
            hit = 1'b1; step(); hit = 1'b0;
            check_val("hit_lives", 32'(lives), 32'(2 - k));
            if (k < 2) begin
                check_val("hit_status", 32'(status), 32'd3);
                repeat (70) step();
            end
        end
        check_val("dead_status", 32'(status), 32'd4);
        check_val("dead_color", 32'(color_o), 32'd8);

        // buttons ignored while dead, then respawn
        btns = 4'b1001; repeat (10) step();
        btns = 4'b0000; respawn = 1'b1; step(); respawn = 1'b0;
        check_val("respawn_h", hPos, 32'd308);
        check_val("respawn_v", vPos, 32'd372);
        check_val("respawn_lives", 32'(lives), 32'd3);
        check_val("respawn_st", 32'(status), 32'd0);

        // reset in the middle of HIT
        hit = 1'b1; step(); hit = 1'b0;
        btns = 4'b1000; repeat (10) step();
        btns = 4'b0000; rst = 1'b0; step(); rst = 1'b1;
        check_val("rst_hit_st", 32'(status), 32'd0);
        check_val("rst_hit_lives", 32'(lives), 32'd3);
        check_val("rst_hit_h", hPos, 32'd308);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            for (int d = 0; d < 4; d++) begin
                if ($urandom_range(7) == 0) btns[d] = ~btns[d];
                en[d] = ($urandom_range(9) != 0);
            end
            hit     = ($urandom_range(119) == 0);
            respawn = ($urandom_range(15) == 0);
            rst     = ($urandom_range(799) != 0);
            if ($urandom_range(31) == 0) color = 3'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
